mux4b_4to1_en: RTL and testbench



---
 rtl/mux4b_4to1_en.sv | 50 +++++
 tb/tb_mux4b_4to1_en.sv | 111 +++++++++++
 2 files changed

// File: rtl/mux4b_4to1_en.sv
`default_nettype none
// ============================================================================
// Module   : mux4b_4to1_en
// Purpose  : Registered 4-to-1 selector with output enable and valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module mux4b_4to1_en #(
  parameter int unsigned      WIDTH          = 4,
  parameter logic [WIDTH-1:0] DISABLED_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             enable,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;

  // Two-level ternary tree: an unknown select bit propagates X to the output
  // in simulation instead of silently picking a source.
  always_comb begin
    w_sel_data = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out       <= DISABLED_VALUE;
      r_out_valid <= 1'b0;
    end else if (!enable) begin
      r_out       <= DISABLED_VALUE;
      r_out_valid <= 1'b0;
    end else begin
      r_out       <= w_sel_data;
      r_out_valid <= 1'b1;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux4b_4to1_en.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4b_4to1_en
// Purpose  : Directed self-checking bench for mux4b_4to1_en.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4b_4to1_en;

  logic       clk;
  logic       rst_n;
  logic [3:0] a, b, c, d;
  logic [1:0] sel;
  logic       enable;
  logic [3:0] out;
  logic       out_valid;

  int checks   = 0;
  int failures = 0;

  mux4b_4to1_en #(.WIDTH(4), .DISABLED_VALUE(4'b0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .sel       (sel),
    .enable    (enable),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] exp_out, input logic exp_valid);
    checks++;
    assert (out === exp_out && out_valid === exp_valid)
      else begin
        failures++;
        $error("FAIL %s: out=%b out_valid=%b expected out=%b out_valid=%b",
               tag, out, out_valid, exp_out, exp_valid);
      end
  endtask

  // Advance one rising edge and sample just after it.
  task automatic tick(input string tag, input logic [3:0] exp_out, input logic exp_valid);
    @(posedge clk);
    #1;
    check(tag, exp_out, exp_valid);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; sel = 2'b00;
    a = 4'b0001; b = 4'b0000; c = 4'b0000; d = 4'b0000;

    // Reset held for two edges while enabled
    tick("reset_edge1", 4'b0000, 1'b0);
    tick("reset_edge2", 4'b0000, 1'b0);
    rst_n = 1'b1;
    tick("reset_release", 4'b0001, 1'b1);

    // Disabled forces idle value, re-enable restores data
    enable = 1'b0; a = 4'b0001; b = 4'b0010; c = 4'b0100; d = 4'b1000; sel = 2'b00;
    tick("disabled", 4'b0000, 1'b0);
    enable = 1'b1;
    tick("reenable", 4'b0001, 1'b1);

    // Select sweep, one sel per cycle
    a = 4'b0010; b = 4'b0011; c = 4'b1110; d = 4'b1111;
    sel = 2'b00; tick("sweep_a", 4'b0010, 1'b1);
    sel = 2'b01; tick("sweep_b", 4'b0011, 1'b1);
    sel = 2'b10; tick("sweep_c", 4'b1110, 1'b1);
    sel = 2'b11; tick("sweep_d", 4'b1111, 1'b1);

    // Data changes under fixed select
    sel = 2'b11;
    d = 4'b1001; tick("track_0", 4'b1001, 1'b1);
    d = 4'b1111; tick("track_1", 4'b1111, 1'b1);
    d = 4'b1010; tick("track_2", 4'b1010, 1'b1);
    d = 4'b1110; tick("track_3", 4'b1110, 1'b1);
    d = 4'b1001; tick("track_4", 4'b1001, 1'b1);

    // Enable toggle 1,0,1
    sel = 2'b10; c = 4'b0101;
    enable = 1'b1; tick("toggle_on1", 4'b0101, 1'b1);
    enable = 1'b0; tick("toggle_off", 4'b0000, 1'b0);
    enable = 1'b1; tick("toggle_on2", 4'b0101, 1'b1);

    // Reset mid-stream; asserting between edges must not act early
    sel = 2'b01; b = 4'b0111;
    tick("mid_pre", 4'b0111, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_async_hold", 4'b0111, 1'b1);
    tick("mid_reset", 4'b0000, 1'b0);
    rst_n = 1'b1;
    tick("mid_recover", 4'b0111, 1'b1);

    // Simultaneous change of sel, data and enable at one edge
    enable = 1'b0;
    tick("simul_pre", 4'b0000, 1'b0);
    enable = 1'b1; sel = 2'b00; a = 4'b1100;
    tick("simul_change", 4'b1100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
